count_monitor: RTL and testbench
================================

Name: count_monitor

Overview:
- Receiving end of the free-running 4-bit counter interface: it samples the counter's output bus and checks that the bus follows a +1 modulo-2^WIDTH sequence.
- Reports lock status, mismatch (error) events, saturating error and wrap counters, and the last value it accepted as good.
- Sits beside any counter under test as an in-design monitor; its outputs are also used by the self-checking bench.

Parameters:
- WIDTH, 4, width of the observed count bus.
- LOCK_CNT, 3, number of consecutive correct increments required to declare lock (legal range 1..15).
- STAT_W, 8, width of the error and wrap statistic counters.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- count_in  input  WIDTH  observed counter value.
- count_valid  input  1  count_in is sampled only on cycles where this is 1.
- locked  output  1  high while the observed sequence is tracked correctly.
- err_pulse  output  1  one-cycle pulse on each mismatch detected while locked.
- err_count  output  STAT_W  number of mismatches while locked; saturates at all-ones.
- wrap_count  output  STAT_W  number of legal all-ones to 0 transitions while locked; saturates at all-ones.
- last_good  output  WIDTH  most recent sample accepted as correct.

Behaviour:
- Reset (synchronous, active-high, dominant over all other inputs):
  - State goes to SEARCH.
  - locked=0, err_pulse=0, err_count=0, wrap_count=0, last_good=0.
  - Internal prev=0, match=0.
- Sampling:
  - Only cycles with count_valid=1 are evaluated; invalid cycles hold all state, and err_pulse is 0.
  - expected = prev + 1, truncated to WIDTH bits, so all-ones wraps to 0.
- FSM states: SEARCH, ACQUIRE, LOCKED.
  - SEARCH, on a valid sample: prev := count_in, match := 0, go to ACQUIRE.
  - ACQUIRE, valid sample equal to expected: prev := count_in, match := match+1. If match+1 == LOCK_CNT, go to LOCKED, set locked=1 and last_good := count_in.
  - ACQUIRE, valid sample not equal to expected: prev := count_in, match := 0, stay in ACQUIRE. No error is counted before lock.
  - LOCKED, valid sample equal to expected: prev := count_in, last_good := count_in. If prev was all-ones (legal wrap), wrap_count increments, saturating.
  - LOCKED, valid sample not equal to expected:
    - err_pulse=1 for exactly one cycle; err_count increments, saturating.
    - locked=0, prev := count_in, match := 0, go to ACQUIRE.
    - last_good holds its value.
- Latency: every output is registered and reflects the sample from the previous edge, i.e. 1 cycle after the sample.
- A repeated value (the source frozen, e.g. held in its own reset) is a mismatch.
- Mismatch on the very first sample after entering ACQUIRE simply recaptures; no pulse is produced.
- Statistic counters never roll over. When they are saturated, err_pulse still fires.
- Reset in the same cycle as a valid mismatch: reset wins, err_pulse=0.
- Reset asserted mid-LOCKED: all outputs clear on that edge, and lock must be reacquired from SEARCH.
- Lock timing: at least LOCK_CNT+1 valid samples are required after reset or after an error.

Decomposition:
- Package count_monitor_pkg holds:
  - the state enumeration (SEARCH=2'd0, ACQUIRE=2'd1, LOCKED=2'd2);
  - the default WIDTH, LOCK_CNT and STAT_W constants.
- One natural sub-module, sat_counter (parameter W; ports clk, reset, inc, value):
  - implements saturating increment;
  - is instantiated twice, for err_count and wrap_count.

Test Plan:
- Reset, then count_valid=1 with count_in = 0,1,2,3 on consecutive cycles -> locked=1 on the cycle after sample 3; last_good=3; err_count=0.
- Continue the sequence 4..15, 0, 1 -> wrap_count=1 one cycle after the 0 sample; last_good=1; locked stays 1; err_pulse never asserted.
- While locked at prev=5, apply count_in=7 -> err_pulse=1 for one cycle, err_count=1, locked=0, last_good=5. Then 8,9,10 -> locked=1 after sample 10.
- While locked, drop count_valid for 3 cycles mid-sequence, then resume with the correct next value -> no error; all outputs hold during the gap.
- Force 300 mismatches, each followed by 4 correct samples -> err_count saturates at 255; err_pulse still fires on every mismatch.
- Assert reset in the same cycle as a mismatching valid sample while locked -> next cycle: err_pulse=0, err_count=0, locked=0, state SEARCH.

Source files
------------

// File: rtl/count_monitor_pkg.sv
// Shared types and default sizing for the count_monitor slice.
package count_monitor_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_t;

  localparam int unsigned DEF_WIDTH    = 4;
  localparam int unsigned DEF_LOCK_CNT = 3;
  localparam int unsigned DEF_STAT_W   = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/count_monitor.sv
// Checks that an observed count bus follows a +1 modulo-2^WIDTH sequence.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
  parameter int unsigned STAT_W   = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              count_valid,
  output logic              locked,
  output logic              err_pulse,
  output logic [STAT_W-1:0] err_count,
  output logic [STAT_W-1:0] wrap_count,
  output logic [WIDTH-1:0]  last_good
);

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  mon_state_t       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [3:0]       match_q, match_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] last_good_q, last_good_d;
  logic             err_inc, wrap_inc;

  logic [WIDTH-1:0] expected;
  logic [3:0]       match_inc;
  logic             hit;

  assign expected  = prev_q + 1'b1;
  assign match_inc = match_q + 4'd1;
  assign hit       = (count_in == expected);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEARCH;
      prev_q      <= '0;
      match_q     <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      last_good_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      match_q     <= match_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      last_good_q <= last_good_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    match_d     = match_q;
    locked_d    = locked_q;
    err_d       = 1'b0;
    last_good_d = last_good_q;
    err_inc     = 1'b0;
    wrap_inc    = 1'b0;
    if (count_valid) begin
      prev_d = count_in;
      case (state_q)
        SEARCH: begin
          match_d = '0;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          if (hit) begin
            match_d = match_inc;
            if (match_inc == LOCK_TGT) begin
              state_d     = LOCKED;
              locked_d    = 1'b1;
              last_good_d = count_in;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if (hit) begin
            last_good_d = count_in;
            wrap_inc    = &prev_q;
          end else begin
            err_d    = 1'b1;
            err_inc  = 1'b1;
            locked_d = 1'b0;
            match_d  = '0;
            state_d  = ACQUIRE;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  sat_counter #(.W(STAT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .value (err_count)
  );

  sat_counter #(.W(STAT_W)) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wrap_inc),
    .value (wrap_count)
  );

  assign locked    = locked_q;
  assign err_pulse = err_q;
  assign last_good = last_good_q;

endmodule

// File: tb/tb_count_monitor.sv
// Directed and randomized checks of count_monitor against a streak-based reference model.
module tb_count_monitor;

  localparam int unsigned LOCK_CNT = 3;
  localparam int unsigned SAT_MAX  = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] count_in;
  logic       count_valid;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;
  logic [7:0] wrap_count;
  logic [3:0] last_good;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a lock is simply a run of >= LOCK_CNT consecutive +1 steps.
  bit         m_have;
  logic [3:0] m_prev;
  int         m_streak;
  bit         m_locked;
  bit         m_pulse;
  int         m_err;
  int         m_wrap;
  logic [3:0] m_lg;

  count_monitor #(.WIDTH(4), .LOCK_CNT(LOCK_CNT), .STAT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .count_in    (count_in),
    .count_valid (count_valid),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_count   (err_count),
    .wrap_count  (wrap_count),
    .last_good   (last_good)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit v, input logic [3:0] val);
    logic [3:0] nx;
    nx = m_prev + 4'd1;
    m_pulse = 1'b0;
    if (rst) begin
      m_have = 0; m_prev = '0; m_streak = 0; m_locked = 0;
      m_err = 0; m_wrap = 0; m_lg = '0;
    end else if (v) begin
      if (!m_have) begin
        m_have = 1; m_streak = 0;
      end else if (val == nx) begin
        if (m_locked && m_prev == 4'hF && m_wrap < SAT_MAX) m_wrap++;
        m_streak++;
        if (m_streak >= LOCK_CNT) begin
          m_locked = 1; m_lg = val;
        end
      end else begin
        if (m_locked) begin
          m_pulse = 1;
          if (m_err < SAT_MAX) m_err++;
        end
        m_locked = 0; m_streak = 0;
      end
      m_prev = val;
    end
  endtask

  task automatic cyc(input bit rst, input bit v, input logic [3:0] val);
    reset = rst; count_valid = v; count_in = val;
    @(posedge clk);
    model_step(rst, v, val);
    #1;
    chk("locked", 32'(locked), 32'(m_locked));
    chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
    chk("err_count", 32'(err_count), 32'(m_err));
    chk("wrap_count", 32'(wrap_count), 32'(m_wrap));
    chk("last_good", 32'(last_good), 32'(m_lg));
  endtask

  function automatic logic [3:0] nxt();
    return m_prev + 4'd1;
  endfunction

  initial begin
    logic [3:0] r;
    reset = 1'b1; count_valid = 1'b0; count_in = '0;
    m_have = 0; m_prev = '0; m_streak = 0; m_locked = 0; m_pulse = 0;
    m_err = 0; m_wrap = 0; m_lg = '0;

    cyc(1, 0, 4'd0);
    cyc(1, 1, 4'd9);

    // Acquire lock from 0 and run through a wrap.
    for (int i = 0; i < 4; i++) cyc(0, 1, 4'(i));
    chk("lock_after_3", 32'(locked), 32'd1);
    chk("lg_after_3", 32'(last_good), 32'd3);
    for (int i = 4; i < 18; i++) cyc(0, 1, 4'(i));
    chk("wrap_once", 32'(wrap_count), 32'd1);
    chk("lg_after_wrap", 32'(last_good), 32'd1);

    // Mismatch while locked at prev=5, then reacquire.
    for (int i = 2; i < 6; i++) cyc(0, 1, 4'(i));
    cyc(0, 1, 4'd7);
    chk("mis_pulse", 32'(err_pulse), 32'd1);
    chk("mis_lg_hold", 32'(last_good), 32'd5);
    cyc(0, 1, 4'd8);
    cyc(0, 1, 4'd9);
    chk("not_yet_locked", 32'(locked), 32'd0);
    cyc(0, 1, 4'd10);
    chk("relock", 32'(locked), 32'd1);

    // Valid gap while locked.
    cyc(0, 1, 4'd11);
    for (int i = 0; i < 3; i++) cyc(0, 0, 4'd3);
    cyc(0, 1, 4'd12);
    cyc(0, 1, 4'd13);

    // Saturate the error counter with frozen-source repeats.
    for (int k = 0; k < 300; k++) begin
      cyc(0, 1, m_prev);
      chk("sat_pulse", 32'(err_pulse), 32'd1);
      for (int j = 0; j < 4; j++) cyc(0, 1, nxt());
    end
    chk("err_sat", 32'(err_count), 32'(SAT_MAX));

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      r = 4'($urandom);
      cyc(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) != 0) ? nxt() : r);
    end

    // Reset colliding with a locked mismatch, then reacquire from SEARCH.
    for (int j = 0; j < 5; j++) cyc(0, 1, nxt());
    chk("pre_rst_locked", 32'(locked), 32'd1);
    cyc(1, 1, m_prev);
    chk("rst_pulse", 32'(err_pulse), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    for (int i = 6; i < 11; i++) cyc(0, 1, 4'(i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
